// File: rtl/cache_request_arbiter_pkg.sv
// Shared definitions for the cache request arbiter.
// Contents: field widths, the flat 104-bit request layout, request-type
// encodings, poison defaults for read requests, and the fill FSM state type.
package cache_request_arbiter_pkg;

  localparam int unsigned INDEX_W  = 6;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned TAG_W    = 22;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned TYPE_W   = 32;
  localparam int unsigned WEN_W    = 4;
  localparam int unsigned SET_W    = 3;
  localparam int unsigned REQ_W    = 104;

  localparam logic [WORD_W-1:0] WORD_POISON_DEF = 32'h0BADF00D;
  localparam logic [TAG_W-1:0]  TAG_POISON_DEF  = 22'h277BAD;

  typedef enum logic [TYPE_W-1:0] {
    REQ_READ  = 32'd0,
    REQ_WRITE = 32'd1,
    REQ_FILL  = 32'd2
  } req_type_e;

  // Field order is MSB first: index sits at [103:98], write_set at [2:0].
  typedef struct packed {
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] block_offset;
    logic [TAG_W-1:0]    tag;
    logic [WORD_W-1:0]   write_data;
    req_type_e           request_type;
    logic                is_valid;
    logic [WEN_W-1:0]    write_enable;
    logic [SET_W-1:0]    write_set;
  } cache_request_t;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_BUSY = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_rr_arbiter2.sv
// Two-way round-robin arbiter between the read port (req[0]) and the write
// port (req[1]).
// Ports: clock, reset (async, active-high); req[1:0] requests; advance = the
// downstream register accepts this cycle; grant_c[1:0] one-hot combinational
// grant.
// When both request, the loser of the last contest wins. A grant to a lone
// requester is not a contest and leaves the preference alone.
module cache_rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_c
);

  logic prefer_wr;

  // Grant selection
  always_comb begin
    grant_c = 2'b00;
    if (req[0] && req[1]) begin
      grant_c = prefer_wr ? 2'b10 : 2'b01;
    end else begin
      grant_c = req;
    end
  end

  // Preference flips to the loser only when a contest is actually resolved
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prefer_wr <= 1'b0;
    end else if (advance && req[0] && req[1]) begin
      prefer_wr <= grant_c[0];
    end
  end

endmodule

// File: rtl/cache_request_arbiter.sv
// Cache request arbiter: merges the read port, the write port and (optionally)
// a 4-beat DRAM line fill into a single registered request to the cache.
// Build option: define CACHE_ARB_FILL_EN to compile in the fill FSM and the
// fill input ports; otherwise fill_busy, fill_done and fill_data_ready are 0.
// Ports:
//   clock, reset             single clock, async active-high reset
//   rd_*                     read port (valid/ready, index, offset)
//   wr_*                     write port (valid/ready, index, offset, tag, data, enable, set)
//   fill_start/index/tag/set fill launch, sampled while fill_busy=0
//   fill_data_valid/ready    fill word stream, fill_data
//   fill_busy, fill_done     fill in progress / one-cycle completion pulse
//   req_valid/req_ready      output handshake, req_data = flat cache_request_t
module cache_request_arbiter
  import cache_request_arbiter_pkg::*;
#(
  parameter logic [WORD_W-1:0] WORD_POISON = WORD_POISON_DEF,
  parameter logic [TAG_W-1:0]  TAG_POISON  = TAG_POISON_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic [WEN_W-1:0]    wr_enable,
  input  logic [SET_W-1:0]    wr_set,
`ifdef CACHE_ARB_FILL_EN
  input  logic                fill_start,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [SET_W-1:0]    fill_set,
  input  logic                fill_data_valid,
  input  logic [WORD_W-1:0]   fill_data,
`endif
  output logic                fill_data_ready,
  output logic                fill_busy,
  output logic                fill_done,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [REQ_W-1:0]    req_data
);

  cache_request_t req_q;
  cache_request_t req_d;
  logic           can_load_c;
  logic           fill_grant_c;
  logic [1:0]     arb_req_c;
  logic [1:0]     arb_grant_c;

  // One-entry output register may load when empty or draining this cycle
  assign can_load_c = !req_valid || req_ready;

  // An active fill beat pre-empts both CPU ports
  assign arb_req_c = {wr_valid, rd_valid} & ~{2{fill_grant_c}};

  cache_rr_arbiter2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (arb_req_c),
    .advance (can_load_c),
    .grant_c (arb_grant_c)
  );

  assign rd_ready        = can_load_c && arb_grant_c[0];
  assign wr_ready        = can_load_c && arb_grant_c[1];
  assign fill_data_ready = can_load_c && fill_grant_c;

`ifdef CACHE_ARB_FILL_EN
  localparam int unsigned BEAT_W = 2;

  fill_state_e         state_q;
  fill_state_e         state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   beat_d;
  logic                last_held_q;
  logic                last_held_d;
  logic                fill_done_d;
  logic [INDEX_W-1:0]  fill_index_q;
  logic [TAG_W-1:0]    fill_tag_q;
  logic [SET_W-1:0]    fill_set_q;

  // Beats stop once the final beat sits in the output register
  assign fill_grant_c = (state_q == FILL_BUSY) && !last_held_q && fill_data_valid;
  assign fill_busy    = (state_q == FILL_BUSY);

  // Fill FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= FILL_IDLE;
      beat_q       <= '0;
      last_held_q  <= 1'b0;
      fill_done    <= 1'b0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      fill_set_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_held_q <= last_held_d;
      fill_done   <= fill_done_d;
      if (state_q == FILL_IDLE && fill_start) begin
        fill_index_q <= fill_index;
        fill_tag_q   <= fill_tag;
        fill_set_q   <= fill_set;
      end
    end
  end

  // Fill FSM next state; completes when the last beat leaves downstream
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_held_d = last_held_q;
    fill_done_d = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          state_d     = FILL_BUSY;
          beat_d      = '0;
          last_held_d = 1'b0;
        end
      end
      FILL_BUSY: begin
        if (fill_grant_c && can_load_c) begin
          beat_d = BEAT_W'(beat_q + 1'b1);
          if (beat_q == BEAT_W'(3)) begin
            last_held_d = 1'b1;
          end
        end
        if (last_held_q && req_ready) begin
          state_d     = FILL_IDLE;
          last_held_d = 1'b0;
          fill_done_d = 1'b1;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end
`else
  assign fill_grant_c = 1'b0;
  assign fill_busy    = 1'b0;
  assign fill_done    = 1'b0;
`endif

  // Request payload for the granted source
  always_comb begin
    req_d          = '0;
    req_d.is_valid = 1'b1;
    if (arb_grant_c[1]) begin
      req_d.index        = wr_index;
      req_d.block_offset = wr_offset;
      req_d.tag          = wr_tag;
      req_d.write_data   = wr_data;
      req_d.request_type = REQ_WRITE;
      req_d.write_enable = wr_enable;
      req_d.write_set    = wr_set;
    end else begin
      req_d.index        = rd_index;
      req_d.block_offset = rd_offset;
      req_d.tag          = TAG_POISON;
      req_d.write_data   = WORD_POISON;
      req_d.request_type = REQ_READ;
      req_d.write_enable = '0;
      req_d.write_set    = '0;
    end
`ifdef CACHE_ARB_FILL_EN
    if (fill_grant_c) begin
      req_d.index        = fill_index_q;
      req_d.block_offset = OFFSET_W'({beat_q, 2'b00});
      req_d.tag          = fill_tag_q;
      req_d.write_data   = fill_data;
      req_d.request_type = REQ_FILL;
      req_d.write_enable = 4'hF;
      req_d.write_set    = fill_set_q;
    end
`endif
  end

  // Output register; payload only changes on a fresh load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_valid <= 1'b0;
      req_q     <= '0;
    end else if (can_load_c) begin
      req_valid <= fill_grant_c || (arb_grant_c != 2'b00);
      if (fill_grant_c || (arb_grant_c != 2'b00)) begin
        req_q <= req_d;
      end
    end
  end

  assign req_data = req_q;

endmodule

// File: tb/tb_cache_request_arbiter.sv
// Directed self-checking bench for cache_request_arbiter.
// Fill scenarios are included when CACHE_ARB_FILL_EN is defined.
module tb_cache_request_arbiter;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd_valid, rd_ready;
  logic [5:0]    rd_index;
  logic [3:0]    rd_offset;
  logic          wr_valid, wr_ready;
  logic [5:0]    wr_index;
  logic [3:0]    wr_offset;
  logic [21:0]   wr_tag;
  logic [31:0]   wr_data;
  logic [3:0]    wr_enable;
  logic [2:0]    wr_set;
`ifdef CACHE_ARB_FILL_EN
  logic          fill_start;
  logic [5:0]    fill_index;
  logic [21:0]   fill_tag;
  logic [2:0]    fill_set;
  logic          fill_data_valid;
  logic [31:0]   fill_data;
`endif
  logic          fill_data_ready, fill_busy, fill_done;
  logic          req_valid, req_ready;
  logic [103:0]  req_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [103:0] rd_exp;
  logic [103:0] wr_exp;

  always #5 clock = ~clock;

  cache_request_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_index        (rd_index),
    .rd_offset       (rd_offset),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_index        (wr_index),
    .wr_offset       (wr_offset),
    .wr_tag          (wr_tag),
    .wr_data         (wr_data),
    .wr_enable       (wr_enable),
    .wr_set          (wr_set),
`ifdef CACHE_ARB_FILL_EN
    .fill_start      (fill_start),
    .fill_index      (fill_index),
    .fill_tag        (fill_tag),
    .fill_set        (fill_set),
    .fill_data_valid (fill_data_valid),
    .fill_data       (fill_data),
`endif
    .fill_data_ready (fill_data_ready),
    .fill_busy       (fill_busy),
    .fill_done       (fill_done),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_data        (req_data)
  );

  task automatic check(input string tag, input logic [103:0] got, input logic [103:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

`ifdef CACHE_ARB_FILL_EN
  function automatic logic [103:0] fill_exp(input logic [1:0] beat, input logic [31:0] w);
    logic [3:0] off;
    off = {beat, 2'b00};
    return {6'h0C, off, 22'h001234, w, 32'd2, 1'b1, 4'hF, 3'd3};
  endfunction
`endif

  initial begin
    reset = 1'b1;
    rd_valid = 0; rd_index = 6'h2A; rd_offset = 4'h5;
    wr_valid = 0; wr_index = 6'h15; wr_offset = 4'hA; wr_tag = 22'h03ABCD;
    wr_data = 32'hDEADBEEF; wr_enable = 4'hA; wr_set = 3'd5;
    req_ready = 1'b0;
`ifdef CACHE_ARB_FILL_EN
    fill_start = 0; fill_index = 6'h0C; fill_tag = 22'h001234; fill_set = 3'd3;
    fill_data_valid = 0; fill_data = '0;
`endif
    rd_exp = {6'h2A, 4'h5, 22'h277BAD, 32'h0BADF00D, 32'd0, 1'b1, 4'h0, 3'h0};
    wr_exp = {6'h15, 4'hA, 22'h03ABCD, 32'hDEADBEEF, 32'd1, 1'b1, 4'hA, 3'd5};

    // Reset state
    tick(); tick();
    check("rst_req_valid", 104'(req_valid), 104'(0));
    check("rst_req_data", req_data, 104'(0));
    check("rst_fill_busy", 104'(fill_busy), 104'(0));
    check("rst_fill_done", 104'(fill_done), 104'(0));
    check("rst_fill_data_ready", 104'(fill_data_ready), 104'(0));
    reset = 1'b0;
    tick();

    // Single read with poison fields
    rd_valid = 1; req_ready = 1;
    settle();
    check("rd_single_ready", 104'(rd_ready), 104'(1));
    tick();
    rd_valid = 0;
    check("rd_single_valid", 104'(req_valid), 104'(1));
    check("rd_single_data", req_data, rd_exp);
    tick();
    check("rd_single_drain", 104'(req_valid), 104'(0));

    // Both ports every cycle: strict alternation starting with read
    rd_valid = 1; wr_valid = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      check("rr_rd_ready", 104'(rd_ready), 104'(i % 2 == 0));
      check("rr_wr_ready", 104'(wr_ready), 104'(i % 2 == 1));
      tick();
      check("rr_valid", 104'(req_valid), 104'(1));
      check("rr_data", req_data, (i % 2 == 0) ? rd_exp : wr_exp);
    end

    // Back-pressure: held write request must not move
    req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("stall_rd_ready", 104'(rd_ready), 104'(0));
      check("stall_wr_ready", 104'(wr_ready), 104'(0));
      tick();
      check("stall_valid", 104'(req_valid), 104'(1));
      check("stall_data", req_data, wr_exp);
    end

    // Release: read wins (write won the last contest), zero-bubble load
    req_ready = 1;
    settle();
    check("release_rd_ready", 104'(rd_ready), 104'(1));
    check("release_wr_ready", 104'(wr_ready), 104'(0));
    tick();
    check("release_data", req_data, rd_exp);

    // Lone read is not a contest; write still owed the next one
    wr_valid = 0;
    settle();
    check("lone_rd_ready", 104'(rd_ready), 104'(1));
    tick();
    wr_valid = 1;
    settle();
    check("owed_wr_ready", 104'(wr_ready), 104'(1));
    check("owed_rd_ready", 104'(rd_ready), 104'(0));
    tick();
    check("owed_data", req_data, wr_exp);
    rd_valid = 0; wr_valid = 0;
    tick();
    check("idle_valid", 104'(req_valid), 104'(0));
    check("nofill_busy", 104'(fill_busy), 104'(0));

`ifdef CACHE_ARB_FILL_EN
    // Fill with reads interleaving only in gaps of the word stream
    fill_start = 1;
    tick();
    fill_start = 0;
    check("fill_busy_set", 104'(fill_busy), 104'(1));
    rd_valid = 1;
    fill_data_valid = 1; fill_data = 32'h11110000;
    settle();
    check("fill_b0_ready", 104'(fill_data_ready), 104'(1));
    check("fill_b0_rd_blocked", 104'(rd_ready), 104'(0));
    tick();
    check("fill_b0_data", req_data, fill_exp(2'd0, 32'h11110000));
    fill_data_valid = 0;
    settle();
    check("fill_gap_rd_ready", 104'(rd_ready), 104'(1));
    check("fill_gap_fdr", 104'(fill_data_ready), 104'(0));
    tick();
    check("fill_gap_data", req_data, rd_exp);
    // A second launch while busy must be ignored
    fill_data_valid = 1; fill_data = 32'h22221111;
    fill_start = 1; fill_tag = 22'h03FFFF;
    tick();
    fill_start = 0; fill_tag = 22'h001234;
    check("fill_b1_data", req_data, fill_exp(2'd1, 32'h22221111));
    fill_data = 32'h33332222;
    tick();
    check("fill_b2_data", req_data, fill_exp(2'd2, 32'h33332222));
    fill_data = 32'h44443333;
    tick();
    check("fill_b3_data", req_data, fill_exp(2'd3, 32'h44443333));
    check("fill_b3_busy", 104'(fill_busy), 104'(1));
    check("fill_b3_done", 104'(fill_done), 104'(0));
    // Extra word offered after the last beat is not taken
    settle();
    check("fill_extra_fdr", 104'(fill_data_ready), 104'(0));
    check("fill_extra_rd_ready", 104'(rd_ready), 104'(1));
    tick();
    check("fill_done_pulse", 104'(fill_done), 104'(1));
    check("fill_busy_clear", 104'(fill_busy), 104'(0));
    check("fill_after_rd", req_data, rd_exp);
    rd_valid = 0; fill_data_valid = 0;
    tick();
    check("fill_done_once", 104'(fill_done), 104'(0));
    check("fill_after_idle", 104'(req_valid), 104'(0));

    // Reset after beat 1 abandons the fill
    fill_start = 1;
    tick();
    fill_start = 0;
    fill_data_valid = 1; fill_data = 32'hAAAA0000;
    tick();
    fill_data = 32'hAAAA1111;
    tick();
    check("rst_mid_pre_valid", 104'(req_valid), 104'(1));
    fill_data_valid = 0;
    reset = 1;
    settle();
    check("rst_mid_valid", 104'(req_valid), 104'(0));
    check("rst_mid_busy", 104'(fill_busy), 104'(0));
    check("rst_mid_done", 104'(fill_done), 104'(0));
    tick();
    reset = 0;
    tick(); tick();
    check("rst_mid_no_done", 104'(fill_done), 104'(0));
    check("rst_mid_still_idle", 104'(fill_busy), 104'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
